// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the future receiver:
// FSM state encoding, parity mode encodings and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_ODD    = 1;
    localparam int PARITY_EVEN   = 2;
    localparam int MAX_DATA_BITS = 9;

    // Words are zero-extended to MAX_DATA_BITS, so the padding never changes the result.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] word, input int mode);
        logic p;
        p = 1'b0;
        if (mode == PARITY_ODD) begin
            p = ~^word;
        end else if (mode == PARITY_EVEN) begin
            p = ^word;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Word handshake plus serial line and status of the UART transmitter.
// master = register/DMA side driving words in, slave = the transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_send_data;
    logic                 i_send_data_valid;
    logic                 o_send_data_ready;
    logic                 uart_tx;
    logic                 uart_busy;
    logic                 o_frame_done;

    modport master (
        output i_send_data,
        output i_send_data_valid,
        input  o_send_data_ready,
        input  uart_tx,
        input  uart_busy,
        input  o_frame_done
    );

    modport slave (
        input  i_send_data,
        input  i_send_data_valid,
        output o_send_data_ready,
        output uart_tx,
        output uart_busy,
        output o_frame_done
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for queued transmit words; read data is the head entry (show-ahead).
// Push is dropped when full and pop when empty; reset flushes the pointers.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with internal baud divider; optional transmit FIFO under UART_TX_FIFO_EN.
// Start bit on the line 1 cycle after transfer (2 with FIFO); ready only in IDLE/last stop cycle, or while FIFO not full.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input logic            sys_clk,
    input logic            sys_reset,
    uart_tx_param_if.slave bus
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
        PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("uart_tx_param: illegal parameter set");
    end

    uart_state_e              state_q, state_d;
    logic [CNT_W-1:0]         baud_q, baud_d;
    logic [3:0]               bit_q, bit_d;
    logic [MAX_DATA_BITS-1:0] word_q, word_d;
    logic                     tx_q, tx_d;
    logic                     done_q, done_d;

    logic                     bit_end, last_stop, can_take, take, transfer;
    logic                     word_avail, pending, par_bit;
    logic [MAX_DATA_BITS-1:0] next_word;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign last_stop = (state_q == STOP) && bit_end && (bit_q == STOP_LAST);
    assign can_take  = ((state_q == IDLE) || last_stop) && !sys_reset;
    assign transfer  = bus.i_send_data_valid && bus.o_send_data_ready;
    assign take      = can_take && word_avail;
    assign par_bit   = calc_parity(word_q, PARITY_MODE);

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .push      (transfer),
        .pop       (take),
        .wdata     (bus.i_send_data),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.o_send_data_ready = !fifo_full && !sys_reset;
    assign word_avail            = !fifo_empty;
    assign next_word             = MAX_DATA_BITS'(fifo_rdata);
    assign pending               = !fifo_empty;
`else
    // Without storage the FSM takes the word straight off the bus.
    assign bus.o_send_data_ready = can_take;
    assign word_avail            = bus.i_send_data_valid;
    assign next_word             = MAX_DATA_BITS'(bus.i_send_data);
    assign pending               = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        baud_d  = ((state_q == IDLE) || bit_end) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        word_d  = word_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = START;
                    word_d  = next_word;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                tx_d = word_q[bit_q];
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                tx_d = par_bit;
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        bit_d   = '0;
                        state_d = take ? START : IDLE;
                        if (take) begin
                            word_d = next_word;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line and done pulse are registered, so both trail the FSM by one cycle and stay aligned.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.uart_tx      = tx_q;
    assign bus.o_frame_done = done_q;
    assign bus.uart_busy    = !sys_reset && ((state_q != IDLE) || pending || transfer);
endmodule
